// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: radix-2 iterative, 32 steps per op.
// Sign handling is done on entry (magnitudes) and exit (correction).
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  input  logic [2:0]       FUNC,
  input  logic             START,
  input  logic             FLUSH,
  output logic [WIDTH-1:0] RESULT,
  output logic             BUSY,
  output logic             DONE
);

  localparam int W = WIDTH;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]     state;
  logic [4:0]     cnt;
  logic [2:0]     op;
  logic           qneg;
  logic           rneg;
  logic [W-1:0]   opb;
  logic [2*W-1:0] acc;

  logic           accept;
  logic           a_sgn, b_sgn;
  logic           a_neg, b_neg;
  logic [W-1:0]   a_mag, b_mag;
  logic           dz, ovf;

  logic [W:0]     mul_sum;
  logic [W:0]     div_sh;
  logic [W:0]     div_df;
  logic           div_ge;

  logic [2*W-1:0] prod;
  logic [W-1:0]   quo, rem;
  logic [W-1:0]   sel;

  assign accept = START & ~FLUSH &
                  ((state == S_IDLE) | (state == S_DONE));

  // Div ops: signed when funct3[0]==0; mul ops per funct3 pair.
  assign a_sgn = FUNC[2] ? ~FUNC[0] : (FUNC[1:0] != 2'b11);
  assign b_sgn = FUNC[2] ? ~FUNC[0] : ~FUNC[1];
  assign a_neg = a_sgn & DATA1[W-1];
  assign b_neg = b_sgn & DATA2[W-1];
  assign a_mag = a_neg ? -DATA1 : DATA1;
  assign b_mag = b_neg ? -DATA2 : DATA2;

  assign dz  = FUNC[2] & (DATA2 == '0);
  assign ovf = FUNC[2] & ~FUNC[0] &
               (DATA1 == {1'b1, {(W-1){1'b0}}}) &
               (DATA2 == {W{1'b1}});

  assign mul_sum = {1'b0, acc[2*W-1:W]} +
                   (acc[0] ? {1'b0, opb} : '0);
  assign div_sh  = {acc[2*W-1:W], acc[W-1]};
  assign div_df  = div_sh - {1'b0, opb};
  assign div_ge  = div_sh >= {1'b0, opb};

  assign prod = qneg ? -acc : acc;
  assign quo  = qneg ? -acc[W-1:0] : acc[W-1:0];
  assign rem  = rneg ? -acc[2*W-1:W] : acc[2*W-1:W];

  // Output select from the sign-corrected product/quotient/remainder.
  always_comb begin
    sel = '0;
    unique case (1'b1)
      (op == 3'b000): sel = prod[W-1:0];
      (op[2] == 1'b0 && op != 3'b000): sel = prod[2*W-1:W];
      (op[2] == 1'b1 && op[1] == 1'b0): sel = quo;
      (op[2] == 1'b1 && op[1] == 1'b1): sel = rem;
      default: sel = '0;
    endcase
  end

  assign BUSY = (state == S_CALC) | (state == S_FIX);
  assign DONE = (state == S_DONE);

  // Control FSM and step counter; flush wins over everything.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else if (FLUSH) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          cnt <= '0;
          if (START)
            state <= (dz | ovf) ? S_FIX : S_CALC;
          else
            state <= S_IDLE;
        end
        S_CALC: begin
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31)
            state <= S_FIX;
        end
        S_FIX: begin
          state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Operand latch on accept, then one shift-add/subtract per CALC cycle.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      op   <= '0;
      qneg <= 1'b0;
      rneg <= 1'b0;
      opb  <= '0;
      acc  <= '0;
    end else if (accept) begin
      op <= FUNC;
      if (dz) begin
        qneg <= 1'b0;
        rneg <= 1'b0;
        opb  <= '0;
        acc  <= {DATA1, {W{1'b1}}};
      end else if (ovf) begin
        qneg <= 1'b0;
        rneg <= 1'b0;
        opb  <= '0;
        acc  <= {{W{1'b0}}, 1'b1, {(W-1){1'b0}}};
      end else if (FUNC[2]) begin
        qneg <= a_neg ^ b_neg;
        rneg <= a_neg;
        opb  <= b_mag;
        acc  <= {{W{1'b0}}, a_mag};
      end else begin
        qneg <= a_neg ^ b_neg;
        rneg <= 1'b0;
        opb  <= a_mag;
        acc  <= {{W{1'b0}}, b_mag};
      end
    end else if (!FLUSH && state == S_CALC) begin
      if (op[2]) begin
        if (div_ge)
          acc <= {div_df[W-1:0], acc[W-2:0], 1'b1};
        else
          acc <= {div_sh[W-1:0], acc[W-2:0], 1'b0};
      end else begin
        acc <= {mul_sum, acc[W-1:1]};
      end
    end
  end

  // Result register: loaded only in FIX, held otherwise.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)
      RESULT <= '0;
    else if (!FLUSH && state == S_FIX)
      RESULT <= sel;
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed cases plus random ops
// against a plain-arithmetic RV32M reference.
module tb_muldiv_unit;

  logic        CLK;
  logic        RESET;
  logic [31:0] DATA1;
  logic [31:0] DATA2;
  logic [2:0]  FUNC;
  logic        START;
  logic        FLUSH;
  logic [31:0] RESULT;
  logic        BUSY;
  logic        DONE;

  int n_pass;
  int n_total;
  logic [31:0] last_exp;

  muldiv_unit #(.WIDTH(32)) dut (
    .CLK(CLK), .RESET(RESET),
    .DATA1(DATA1), .DATA2(DATA2),
    .FUNC(FUNC), .START(START), .FLUSH(FLUSH),
    .RESULT(RESULT), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_total++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] ref_op(input logic [2:0] f,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    logic signed [63:0] sa, sb, sub;
    logic [63:0] ua, ub, p;
    int q;
    logic ov;
    sa  = $signed({{32{a[31]}}, a});
    sb  = $signed({{32{b[31]}}, b});
    sub = $signed({32'b0, b});
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    ov  = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
    p   = '0;
    q   = 0;
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * sub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (ov) return 32'h80000000;
        q = $signed(a) / $signed(b);
        return q;
      end
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ov) return 32'h0;
        q = $signed(a) % $signed(b);
        return q;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
    if (f[2] && b == 0) return 1;
    if (f[2] && !f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF)
      return 1;
    return 33;
  endfunction

  // Called at #1 after an edge with the DUT in IDLE or DONE.
  task automatic do_op(input string tag, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] b);
    int n;
    logic bz;
    logic [31:0] exp;
    exp = ref_op(f, a, b);
    FUNC = f; DATA1 = a; DATA2 = b; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    FUNC = 3'($urandom);
    DATA1 = $urandom;
    DATA2 = $urandom;
    n = 0;
    bz = 1'b1;
    while (!DONE && n < 40) begin
      if (!BUSY) bz = 1'b0;
      @(posedge CLK); #1;
      n++;
    end
    chk({tag, " lat"}, n, ref_lat(f, a, b));
    chk({tag, " busy"}, {31'b0, bz}, 32'd1);
    chk({tag, " res"}, RESULT, exp);
    last_exp = exp;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bit seen;
    n_pass = 0;
    n_total = 0;
    last_exp = '0;
    CLK = 0; RESET = 0; START = 0; FLUSH = 0;
    FUNC = '0; DATA1 = '0; DATA2 = '0;
    #1;
    chk("rst result", RESULT, 32'h0);
    chk("rst busy", {31'b0, BUSY}, 32'd0);
    chk("rst done", {31'b0, DONE}, 32'd0);
    #12 RESET = 1;
    @(posedge CLK); #1;

    do_op("mul", 3'd0, 32'd7, 32'hFFFFFFFD);
    chk("mul busy in done", {31'b0, BUSY}, 32'd0);
    @(posedge CLK); #1;
    chk("done one cycle", {31'b0, DONE}, 32'd0);

    do_op("mulh", 3'd1, 32'h80000000, 32'h80000000);
    do_op("mulhu", 3'd3, 32'h80000000, 32'h80000000);
    do_op("mulhsu", 3'd2, 32'h80000000, 32'h80000000);
    do_op("div", 3'd4, 32'hFFFFFFF9, 32'd2);
    do_op("rem", 3'd6, 32'hFFFFFFF9, 32'd2);
    do_op("divu0", 3'd5, 32'h12345678, 32'd0);
    do_op("remu0", 3'd7, 32'h12345678, 32'd0);
    do_op("divovf", 3'd4, 32'h80000000, 32'hFFFFFFFF);
    do_op("removf", 3'd6, 32'h80000000, 32'hFFFFFFFF);
    @(posedge CLK); #1;

    // Flush mid-calculation
    FUNC = 3'd0; DATA1 = 32'd1234; DATA2 = 32'd5678; START = 1;
    @(posedge CLK); #1;
    START = 0;
    repeat (10) @(posedge CLK);
    #1 FLUSH = 1;
    @(posedge CLK); #1;
    FLUSH = 0;
    chk("flush busy", {31'b0, BUSY}, 32'd0);
    chk("flush done", {31'b0, DONE}, 32'd0);
    chk("flush result", RESULT, last_exp);
    seen = 0;
    repeat (40) begin
      @(posedge CLK); #1;
      if (DONE) seen = 1;
    end
    chk("flush no done", {31'b0, seen}, 32'd0);
    chk("flush hold", RESULT, last_exp);

    // Flush beats a simultaneous start
    FUNC = 3'd4; DATA1 = 32'd100; DATA2 = 32'd7;
    START = 1; FLUSH = 1;
    @(posedge CLK); #1;
    START = 0; FLUSH = 0;
    chk("flush+start busy", {31'b0, BUSY}, 32'd0);
    seen = 0;
    repeat (36) begin
      @(posedge CLK); #1;
      if (DONE || BUSY) seen = 1;
    end
    chk("flush+start idle", {31'b0, seen}, 32'd0);

    // Asynchronous reset mid-calculation
    do_op("pre-rst", 3'd1, 32'hDEADBEEF, 32'h12345678);
    FUNC = 3'd5; DATA1 = 32'd999; DATA2 = 32'd10; START = 1;
    @(posedge CLK); #1;
    START = 0;
    repeat (5) @(posedge CLK);
    #1 RESET = 0;
    #1;
    chk("arst busy", {31'b0, BUSY}, 32'd0);
    chk("arst done", {31'b0, DONE}, 32'd0);
    chk("arst result", RESULT, 32'h0);
    #5 RESET = 1;
    @(posedge CLK); #1;
    do_op("post-rst", 3'd5, 32'd999, 32'd10);

    // Random ops, some back-to-back
    for (int i = 0; i < 40; i++) begin
      do_op("rand", 3'($urandom_range(0, 7)), pick(), pick());
      if ($urandom_range(0, 1) == 1) begin
        START = 0;
        @(posedge CLK); #1;
        chk("rand done drop", {31'b0, DONE}, 32'd0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
